instruction_fetch_stage: RTL and testbench

Front-end fetch stage that produces the 32-bit instruction word consumed by the decode interface. It owns the program counter and issues word-aligned reads to instruction memory, buffering returned words with their PC in a small FIFO. It presents them to decode over a valid/ready handshake and supports a pipeline redirect (branch/jump/trap) that flushes all buffered and in-flight fetches.

---
 rtl/instruction_fetch_stage_if.sv | 65 ++++++
 rtl/instruction_fetch_stage.sv | 196 +++++++++++++++++++
 tb/tb_instruction_fetch_stage.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_stage_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_stage_if
//
// Bundles the handshake and bus signals of the fetch stage: the instruction
// memory request/response channel, the pipeline redirect, and the decode
// valid/ready channel.
//
// Modports:
//   master - the fetch stage itself (drives requests and the decode channel)
//   slave  - the environment (memory, redirect source and decode)
//
// Signals:
//   imem_req_valid  fetch -> mem   read request valid
//   imem_req_ready  mem -> fetch   memory accepts request this cycle
//   imem_req_addr   fetch -> mem   word-aligned read address
//   imem_rsp_valid  mem -> fetch   read data valid (in order, never stalled)
//   imem_rsp_data   mem -> fetch   read data
//   redirect_valid  env -> fetch   flush and restart fetch
//   redirect_pc     env -> fetch   new PC, bits [1:0] ignored
//   if_valid        fetch -> dec   if_instruction/if_pc valid
//   if_ready        dec -> fetch   decode accepts the word
//   if_instruction  fetch -> dec   instruction word
//   if_pc           fetch -> dec   PC of if_instruction
// ---------------------------------------------------------------------------
interface instruction_fetch_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    output if_valid,
    output if_instruction,
    output if_pc,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  redirect_valid,
    input  redirect_pc,
    input  if_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    input  if_valid,
    input  if_instruction,
    input  if_pc,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    output redirect_valid,
    output redirect_pc,
    output if_ready
  );
endinterface

// File: rtl/instruction_fetch_stage.sv
// ---------------------------------------------------------------------------
// instruction_fetch_stage
//
// Front-end fetch stage. Owns the program counter, issues word-aligned reads
// to instruction memory, buffers returned words together with their PC in a
// small FIFO and hands them to decode over a valid/ready handshake. A
// redirect flushes the FIFO and discards every response still in flight.
//
// Parameters:
//   RESET_PC    PC of the first fetch after reset (bits [1:0] must be 0)
//   FIFO_DEPTH  fetch buffer entries, power of two, at least 2
//
// Ports:
//   clk               single clock, rising edge
//   rst_n             synchronous active-low reset
//   bus               instruction_fetch_stage_if.master (memory, redirect,
//                     decode channels)
//   perf_fetch_count  number of decode handshakes, wraps at 2^32
//                     (present only when INSTR_FETCH_PERF_EN is defined)
//
// Optional feature macro: INSTR_FETCH_PERF_EN
// ---------------------------------------------------------------------------
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
`ifdef INSTR_FETCH_PERF_EN
  output logic [31:0]                perf_fetch_count,
`endif
  instruction_fetch_stage_if.master  bus
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  typedef enum logic [0:0] {
    StRun,
    StDrain
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic [31:0]     rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0] out_q, out_d;
  logic [CntW-1:0] drop_q, drop_d;
  logic [CntW-1:0] occ_q, occ_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;

  logic [31:0]     fifo_pc_q    [FIFO_DEPTH];
  logic [31:0]     fifo_instr_q [FIFO_DEPTH];

  logic            redirect;
  logic            rsp;
  logic            credit_ok;
  logic            req_valid;
  logic            req_fire;
  logic            push;
  logic            pop;
  logic [CntW:0]   in_flight;
  logic [31:0]     redirect_base;
  logic            unused_redirect_lsb;

  assign redirect            = bus.redirect_valid;
  assign rsp                 = bus.imem_rsp_valid;
  assign redirect_base       = {bus.redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

  // Credit uses registered occupancy only, so if_ready never reaches the
  // request path combinationally; every accepted request owns a FIFO slot.
  assign in_flight = {1'b0, occ_q} + {1'b0, out_q};
  assign credit_ok = in_flight < (CntW + 1)'(FIFO_DEPTH);

  // rst_n gating keeps the request low while reset is held.
  assign req_valid = rst_n && (state_q == StRun) && !redirect && credit_ok;
  assign req_fire  = req_valid && bus.imem_req_ready;

  // Responses are only kept in RUN without a redirect; anything else is stale.
  assign push = rsp && (state_q == StRun) && !redirect;
  assign pop  = (occ_q != '0) && bus.if_ready;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    rsp_pc_d = rsp_pc_q;
    drop_d   = drop_q;
    out_d    = out_q + CntW'(req_fire) - CntW'(rsp);
    occ_d    = occ_q + CntW'(push) - CntW'(pop);
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

    unique case (state_q)
      StRun: begin
        if (req_fire) req_pc_d = req_pc_q + 32'd4;
        if (push)     rsp_pc_d = rsp_pc_q + 32'd4;
      end
      StDrain: begin
        if (rsp) begin
          drop_d = drop_q - CntW'(1);
          if (drop_q == CntW'(1)) state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase

    // Redirect overrides everything. A response arriving in this cycle is
    // already accounted for (and discarded), so it is excluded from drop.
    if (redirect) begin
      req_pc_d = redirect_base;
      rsp_pc_d = redirect_base;
      drop_d   = out_q - CntW'(rsp);
      state_d  = (drop_d != '0) ? StDrain : StRun;
      occ_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StRun;
      req_pc_q <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage needs no reset: outputs are masked while it is empty.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      fifo_pc_q[wr_ptr_q]    <= rsp_pc_q;
      fifo_instr_q[wr_ptr_q] <= bus.imem_rsp_data;
    end
  end

  // The credit rule must make this unreachable.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      assert (occ_q < CntW'(FIFO_DEPTH));
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    bus.imem_req_valid = req_valid;
    bus.imem_req_addr  = req_pc_q;
    bus.if_valid       = (occ_q != '0);
    bus.if_pc          = '0;
    bus.if_instruction = '0;
    if (occ_q != '0) begin
      bus.if_pc          = fifo_pc_q[rd_ptr_q];
      bus.if_instruction = fifo_instr_q[rd_ptr_q];
    end
  end

`ifdef INSTR_FETCH_PERF_EN
  logic [31:0] perf_cnt_q, perf_cnt_d;

  // Counts every decode handshake, including one in a redirect cycle.
  assign perf_cnt_d = pop ? perf_cnt_q + 32'd1 : perf_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cnt_q <= '0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
    end
  end

  assign perf_fetch_count = perf_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_stage
//
// Randomized bench for instruction_fetch_stage. A behavioural memory returns
// addr ^ 32'hA5A5_A5A5 in order with random latency. The reference model
// tracks the expected decode PC stream, the expected next request address,
// the words owed to decode and the requests still in flight (tagged with the
// redirect epoch that issued them), and derives the expected handshake
// outputs from those.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_stage;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam int unsigned Depth   = 2;
  localparam logic [31:0] Key     = 32'hA5A5_A5A5;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  instruction_fetch_stage_if bus ();

`ifdef INSTR_FETCH_PERF_EN
  logic [31:0] perf_fetch_count;
`endif

  instruction_fetch_stage #(
    .RESET_PC   (ResetPc),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
`ifdef INSTR_FETCH_PERF_EN
    .perf_fetch_count (perf_fetch_count),
`endif
    .bus              (bus)
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned epoch;
    int unsigned due;
  } mem_req_t;

  mem_req_t    mq[$];
  int unsigned cyc       = 0;
  int unsigned epoch     = 0;
  int unsigned last_due  = 0;
  logic [31:0] exp_req   = ResetPc;
  logic [31:0] exp_pc    = ResetPc;
  int          buffered  = 0;
  logic [31:0] hs_count  = 0;
  logic        rst_prev  = 1'b0;
  logic        rsp_now   = 1'b0;

  int unsigned ready_pct    = 100;
  int unsigned if_ready_pct = 100;
  int unsigned lat_min      = 1;
  int unsigned lat_max      = 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive at posedge+1, evaluate and update the model at
  // negedge for the edge that follows.
  task automatic run_cycle(input logic rst_val, input logic redir, input logic [31:0] redir_pc);
    logic        old_pending;
    logic        exp_req_valid;
    int unsigned lat;
    int unsigned due;

    @(posedge clk);
    cyc++;
    #1;
    rst_n              = rst_val;
    bus.imem_req_ready = ($urandom_range(99) < ready_pct);
    bus.if_ready       = ($urandom_range(99) < if_ready_pct);
    bus.redirect_valid = rst_val && redir;
    bus.redirect_pc    = redir_pc;
    rsp_now            = rst_val && (mq.size() > 0) && (mq[0].due <= cyc);
    bus.imem_rsp_valid = rsp_now;
    bus.imem_rsp_data  = rsp_now ? (mq[0].addr ^ Key) : $urandom();

    @(negedge clk);

    if (!rst_val) begin
      check_eq("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      if (rst_prev) begin
        check_eq("rst_if_valid", 32'(bus.if_valid), 32'd0);
        check_eq("rst_req_addr", bus.imem_req_addr, ResetPc);
        check_eq("rst_if_pc", bus.if_pc, 32'd0);
        check_eq("rst_if_instr", bus.if_instruction, 32'd0);
`ifdef INSTR_FETCH_PERF_EN
        check_eq("rst_perf", perf_fetch_count, 32'd0);
`endif
      end
      mq.delete();
      buffered = 0;
      exp_req  = ResetPc;
      exp_pc   = ResetPc;
      hs_count = 0;
      last_due = 0;
      epoch++;
      rst_prev = 1'b1;
      return;
    end
    rst_prev = 1'b0;

    old_pending = 1'b0;
    foreach (mq[i]) if (mq[i].epoch != epoch) old_pending = 1'b1;
    exp_req_valid = !redir && !old_pending && ((mq.size() + buffered) < Depth);

    check_eq("if_valid", 32'(bus.if_valid), 32'(buffered != 0));
    check_eq("req_valid", 32'(bus.imem_req_valid), 32'(exp_req_valid));
    if (bus.imem_req_valid) check_eq("req_addr", bus.imem_req_addr, exp_req);
`ifdef INSTR_FETCH_PERF_EN
    check_eq("perf_count", perf_fetch_count, hs_count);
`endif

    if (bus.if_valid && bus.if_ready) begin
      check_eq("if_pc", bus.if_pc, exp_pc);
      check_eq("if_instr", bus.if_instruction, exp_pc ^ Key);
      exp_pc   = exp_pc + 32'd4;
      buffered = buffered - 1;
      hs_count = hs_count + 32'd1;
    end

    if (bus.imem_req_valid && bus.imem_req_ready) begin
      lat      = $urandom_range(lat_max, lat_min);
      due      = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = due;
      mq.push_back('{addr: bus.imem_req_addr, epoch: epoch, due: due});
      exp_req  = exp_req + 32'd4;
    end

    if (rsp_now) begin
      if (mq[0].epoch == epoch && !redir) buffered = buffered + 1;
      void'(mq.pop_front());
    end

    if (redir) begin
      epoch++;
      exp_req  = {redir_pc[31:2], 2'b00};
      exp_pc   = {redir_pc[31:2], 2'b00};
      buffered = 0;
    end
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(3))
      0:       return 32'h0000_1002;
      1:       return 32'hFFFF_FFF8;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    rst_n              = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.if_ready       = 1'b0;

    repeat (3) run_cycle(1'b0, 1'b0, '0);

    // Streaming with an always-ready memory and decode.
    repeat (30) run_cycle(1'b1, 1'b0, '0);

    // Decode stalls for 10 cycles, then resumes.
    if_ready_pct = 0;
    repeat (10) run_cycle(1'b1, 1'b0, '0);
    if_ready_pct = 100;
    repeat (20) run_cycle(1'b1, 1'b0, '0);

    // Redirect with two requests in flight; both responses must be dropped.
    lat_min = 2;
    lat_max = 3;
    for (int i = 0; i < 50 && mq.size() < 2; i++) run_cycle(1'b1, 1'b0, '0);
    check_eq("two_in_flight", 32'(mq.size()), 32'd2);
    run_cycle(1'b1, 1'b1, 32'h0000_1002);
    repeat (20) run_cycle(1'b1, 1'b0, '0);

    // Wrap-around of the PC.
    lat_min = 1;
    lat_max = 1;
    run_cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (20) run_cycle(1'b1, 1'b0, '0);

    // Random traffic with redirects.
    lat_max      = 3;
    ready_pct    = 70;
    if_ready_pct = 70;
    for (int i = 0; i < 1500; i++) begin
      run_cycle(1'b1, ($urandom_range(15) == 0), pick_target());
    end

    // One-cycle reset mid-stream.
    run_cycle(1'b0, 1'b0, '0);
    ready_pct    = 100;
    if_ready_pct = 100;
    lat_max      = 1;
    repeat (30) run_cycle(1'b1, 1'b0, '0);

    // More random traffic.
    lat_max      = 3;
    ready_pct    = 80;
    if_ready_pct = 60;
    for (int i = 0; i < 500; i++) begin
      run_cycle(1'b1, ($urandom_range(11) == 0), pick_target());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
